alu_acc_ctrl: RTL and testbench
===============================

ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 Parameter: WIDTH, 5, datapath width; must match the ALU's A/B/R width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  block can accept a command this cycle.
REQ-006 in_load  input  1  1 = load in_operand into accumulator; 0 = ALU operation.
REQ-007 in_op  input  2  ALU operation code.
REQ-008 in_operand  input  WIDTH  B-side operand or load value.
REQ-009 in_cin  input  1  per-command carry-in; used only when ALU_CHAIN_CARRY_EN is undefined.
REQ-010 alu_a / alu_b  output  WIDTH  operands driven to the ALU.
REQ-011 alu_cin  output  1  carry-in driven to the ALU.
REQ-012 alu_op  output  2  op code driven to the ALU.
REQ-013 alu_r  input  WIDTH  ALU result, combinational from alu_* outputs.
REQ-014 alu_c  input  1  ALU carry-out.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_result  output  WIDTH  accumulator value; out_carry  output  1  carry flag.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESULT; in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE with in_valid=1: capture in_op, in_operand, in_cin; if in_load=1 set acc=in_operand, carry=0, go RESULT; else go EXEC.
REQ-020 IDLE with in_valid=0 SHALL hold state and all registers.
REQ-021 alu_a SHALL equal acc, alu_b the captured operand, alu_op the captured op, registered values only, stable for the whole EXEC cycle.
REQ-022 At the end of EXEC, acc SHALL take alu_r and carry SHALL take alu_c; next state RESULT.
REQ-023 Latency: command accepted at edge N -> out_valid=1 from edge N+2 (ALU op) or N+1 (load).
REQ-024 RESULT: out_valid=1, out_result=acc, out_carry=carry; hold until out_ready=1, then IDLE at next edge.
REQ-025 in_valid during EXEC/RESULT SHALL be ignored (no capture, no loss of current result); no same-cycle RESULT->accept bypass.
REQ-026 out_valid SHALL be 0 outside RESULT; out_result/out_carry SHALL still show acc/carry.
REQ-027 Arithmetic is performed solely by the ALU; this block SHALL NOT modify alu_r (no extension, wrap is the ALU's).

Reset
REQ-028 rst=1 at any edge, including mid-EXEC or RESULT, SHALL force IDLE, acc=0, carry=0, captured op/operand=0, out_valid=0, in_ready=1 after the edge.
REQ-029 A command presented during rst=1 SHALL be discarded.

Configuration
REQ-030 Macro ALU_CHAIN_CARRY_EN defined: alu_cin SHALL equal stored carry flag (multi-word chaining), in_cin ignored.
REQ-031 Macro undefined: alu_cin SHALL equal the in_cin captured with the command; carry flag still updated from alu_c.

Verification (bench drives alu_r/alu_c as an ALU model)
REQ-032 Reset then load 5'b10000 -> out_valid one cycle after accept, out_result=10000, out_carry=0, in_ready=0 until out_ready.
REQ-033 acc=10000, command op=0 operand=01100; bench returns alu_r=11100, alu_c=0 -> during EXEC alu_a=10000, alu_b=01100, alu_op=0; out_result=11100 two cycles after accept.
REQ-034 acc=11101, op=0 operand=01100, alu_r=01001 alu_c=1; next op with ALU_CHAIN_CARRY_EN defined -> alu_cin=1; undefined with in_cin=0 -> alu_cin=0.
REQ-035 Hold out_ready=0 for 5 cycles while pulsing in_valid -> out_valid stays 1, result unchanged, no command captured; out_ready=1 -> IDLE next edge.
REQ-036 Assert rst during EXEC -> next edge IDLE, acc=0, carry=0, out_valid=0, and the ALU result is not captured.

Source files
------------

// File: rtl/alu_acc_ctrl.sv
// ---------------------------------------------------------------------------
// alu_acc_ctrl
//
// Purpose:
//   Accumulator controller that sits in front of an external combinational
//   ALU. It accepts one command at a time, which is either a load or an ALU
//   operation. For an ALU operation it drives the accumulator and the
//   captured operand to the ALU for one EXEC cycle, then stores the ALU
//   result and carry-out. The result is presented until the consumer takes it.
//
// Configuration macro:
//   ALU_CHAIN_CARRY_EN
//     - defined   : alu_cin is driven from the stored carry flag, so that
//                   multi-word operations can be chained. in_cin is ignored.
//     - undefined : alu_cin is driven from the in_cin captured with the
//                   command. This is the default build.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   command handshake (in_ready is high only in IDLE)
//   in_load          1 = load in_operand into acc, 0 = ALU operation
//   in_op            ALU op code
//   in_operand       B operand or load value
//   in_cin           per-command carry-in
//   alu_a/alu_b      operands to ALU (acc / captured operand, registered)
//   alu_cin, alu_op  carry-in and op code to ALU (registered)
//   alu_r, alu_c     ALU result and carry-out (combinational from alu_*)
//   out_valid/ready  result handshake (out_valid is high only in RESULT)
//   out_result       accumulator value (always visible)
//   out_carry        carry flag (always visible)
//   dbg_state        current FSM state: 0 = IDLE, 1 = EXEC, 2 = RESULT
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it stays stable until that edge. The ready
// signal never depends combinationally on valid.
// ---------------------------------------------------------------------------
module alu_acc_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_operand,
    input  logic             in_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] operand_q;

`ifndef ALU_CHAIN_CARRY_EN
    logic             cin_q;
`endif

    // Next-state logic. Commands are taken only in IDLE. A command arriving
    // while in EXEC or RESULT is ignored. Leaving RESULT always passes
    // through IDLE, so a command is never accepted in the same cycle that a
    // result is released.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = in_load ? RESULT : EXEC;
                end
            end
            EXEC:    state_nxt = RESULT;
            RESULT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            carry     <= 1'b0;
            op_q      <= 2'b00;
            operand_q <= '0;
`ifndef ALU_CHAIN_CARRY_EN
            cin_q     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= in_op;
                operand_q <= in_operand;
`ifndef ALU_CHAIN_CARRY_EN
                cin_q     <= in_cin;
`endif
                if (in_load) begin
                    acc   <= in_operand;
                    carry <= 1'b0;
                end
            end
            // The ALU result is stored exactly as returned. Width and wrap
            // behaviour belong to the ALU.
            if (state == EXEC) begin
                acc   <= alu_r;
                carry <= alu_c;
            end
        end
    end

    // The ALU inputs come only from registers, so they stay stable for the
    // whole EXEC cycle.
    assign alu_a  = acc;
    assign alu_b  = operand_q;
    assign alu_op = op_q;

`ifdef ALU_CHAIN_CARRY_EN
    assign alu_cin = carry;
    logic unused_in_cin;
    assign unused_in_cin = in_cin;
`else
    assign alu_cin = cin_q;
`endif

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == RESULT);
    assign out_result = acc;
    assign out_carry  = carry;
    assign dbg_state  = state;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_ctrl
//
// Directed bench for alu_acc_ctrl. The bench acts as the ALU: each scenario
// sets alu_r/alu_c to hand-computed values before the EXEC cycle. Inputs are
// driven 1 time unit after the rising edge. Outputs are sampled at the same
// point, after the registers have settled.
// ---------------------------------------------------------------------------
module tb_alu_acc_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_load;
    logic [1:0]   in_op;
    logic [W-1:0] in_operand;
    logic         in_cin;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_cin;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_r;
    logic         alu_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    alu_acc_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_op      (in_op),
        .in_operand (in_operand),
        .in_cin     (in_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_op     (alu_op),
        .alu_r      (alu_r),
        .alu_c      (alu_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Presents a command for one edge. The caller guarantees the DUT is in IDLE.
    task automatic send_cmd(input logic load, input logic [1:0] op,
                            input logic [W-1:0] operand, input logic cin);
        in_valid   = 1'b1;
        in_load    = load;
        in_op      = op;
        in_operand = operand;
        in_cin     = cin;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // A load command is presented during reset and must be discarded.
        rst = 1'b1; in_valid = 1'b1; in_load = 1'b1; in_operand = 5'b10101;
        in_op = 2'd3; in_cin = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_result !== 5'b00000 || out_carry !== 1'b0) begin bad++; $display("FAIL reset_acc got=%b/%b exp=00000/0", out_result, out_carry); end
        total++; if (alu_b !== 5'b00000 || alu_op !== 2'd0 || alu_cin !== 1'b0) begin bad++; $display("FAIL reset_capture got b=%b op=%0d cin=%b exp 0", alu_b, alu_op, alu_cin); end
        // With in_valid low in IDLE, the state and all registers hold.
        tick();
        total++; if (dbg_state !== S_IDLE || out_result !== 5'b00000 || in_ready !== 1'b1) begin bad++; $display("FAIL idle_hold got st=%0d acc=%b exp st=0 acc=00000", dbg_state, out_result); end
    endtask

    task automatic test_load();
        send_cmd(1'b1, 2'd0, 5'b10000, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL load_latency out_valid got=%b exp=1", out_valid); end
        total++; if (out_result !== 5'b10000 || out_carry !== 1'b0) begin bad++; $display("FAIL load_value got=%b/%b exp=10000/0", out_result, out_carry); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready got=%b exp=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL load_hold got rdy=%b vld=%b exp 0/1", in_ready, out_valid); end
        release_result();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL load_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
        total++; if (out_result !== 5'b10000) begin bad++; $display("FAIL idle_shows_acc got=%b exp=10000", out_result); end
    endtask

    task automatic test_exec();
        alu_r = 5'b11100; alu_c = 1'b0;
        send_cmd(1'b0, 2'd0, 5'b01100, 1'b1);
        total++; if (dbg_state !== S_EXEC || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL exec_state got st=%0d vld=%b rdy=%b exp 1/0/0", dbg_state, out_valid, in_ready); end
        total++; if (alu_a !== 5'b10000 || alu_b !== 5'b01100 || alu_op !== 2'd0) begin bad++; $display("FAIL exec_alu_in got a=%b b=%b op=%0d exp 10000/01100/0", alu_a, alu_b, alu_op); end
`ifndef ALU_CHAIN_CARRY_EN
        total++; if (alu_cin !== 1'b1) begin bad++; $display("FAIL exec_cin got=%b exp=1", alu_cin); end
`else
        total++; if (alu_cin !== 1'b0) begin bad++; $display("FAIL exec_cin_chain got=%b exp=0", alu_cin); end
`endif
        tick();
        total++; if (out_valid !== 1'b1 || out_result !== 5'b11100 || out_carry !== 1'b0) begin bad++; $display("FAIL exec_result got vld=%b r=%b c=%b exp 1/11100/0", out_valid, out_result, out_carry); end
        release_result();
    endtask

    task automatic test_carry_chain();
        send_cmd(1'b1, 2'd0, 5'b11101, 1'b0);
        release_result();
        alu_r = 5'b01001; alu_c = 1'b1;
        send_cmd(1'b0, 2'd0, 5'b01100, 1'b0);
        tick();
        total++; if (out_result !== 5'b01001 || out_carry !== 1'b1) begin bad++; $display("FAIL carry_result got=%b/%b exp=01001/1", out_result, out_carry); end
        release_result();
        alu_r = 5'b00111; alu_c = 1'b0;
        send_cmd(1'b0, 2'd1, 5'b00001, 1'b0);
        total++; if (alu_op !== 2'd1 || alu_a !== 5'b01001 || alu_b !== 5'b00001) begin bad++; $display("FAIL chain_alu_in got a=%b b=%b op=%0d exp 01001/00001/1", alu_a, alu_b, alu_op); end
`ifdef ALU_CHAIN_CARRY_EN
        total++; if (alu_cin !== 1'b1) begin bad++; $display("FAIL chain_cin got=%b exp=1", alu_cin); end
`else
        total++; if (alu_cin !== 1'b0) begin bad++; $display("FAIL chain_cin got=%b exp=0", alu_cin); end
`endif
        tick();
        total++; if (out_result !== 5'b00111 || out_carry !== 1'b0) begin bad++; $display("FAIL chain_result got=%b/%b exp=00111/0", out_result, out_carry); end
        // The result is left pending for test_hold.
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_load = 1'b1; in_operand = 5'b11111; in_op = 2'd2; in_cin = 1'b1;
            tick();
            total++; if (out_valid !== 1'b1 || out_result !== 5'b00111 || alu_b !== 5'b00001 || alu_op !== 2'd1) begin bad++; $display("FAIL hold_cycle%0d got vld=%b r=%b b=%b op=%0d exp 1/00111/00001/1", i, out_valid, out_result, alu_b, alu_op); end
        end
        // When leaving RESULT, the command is still asserted and must not be taken.
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (dbg_state !== S_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got st=%0d rdy=%b vld=%b exp 0/1/0", dbg_state, in_ready, out_valid); end
        total++; if (out_result !== 5'b00111 || alu_b !== 5'b00001) begin bad++; $display("FAIL no_bypass got r=%b b=%b exp 00111/00001", out_result, alu_b); end
    endtask

    task automatic test_reset_exec();
        send_cmd(1'b1, 2'd0, 5'b00011, 1'b0);
        release_result();
        alu_r = 5'b11111; alu_c = 1'b1;
        send_cmd(1'b0, 2'd3, 5'b00110, 1'b1);
        total++; if (dbg_state !== S_EXEC) begin bad++; $display("FAIL rst_exec_pre got=%0d exp=1", dbg_state); end
        do_reset();
        total++; if (dbg_state !== S_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_exec_state got st=%0d rdy=%b vld=%b exp 0/1/0", dbg_state, in_ready, out_valid); end
        total++; if (out_result !== 5'b00000 || out_carry !== 1'b0) begin bad++; $display("FAIL rst_exec_acc got=%b/%b exp=00000/0", out_result, out_carry); end
        total++; if (alu_b !== 5'b00000 || alu_op !== 2'd0) begin bad++; $display("FAIL rst_exec_capture got b=%b op=%0d exp 0/0", alu_b, alu_op); end
        tick();
        total++; if (dbg_state !== S_IDLE || out_result !== 5'b00000) begin bad++; $display("FAIL rst_exec_after got st=%0d r=%b exp 0/00000", dbg_state, out_result); end
    endtask

    task automatic test_reset_result();
        send_cmd(1'b1, 2'd0, 5'b01010, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_res_pre got=%b exp=1", out_valid); end
        do_reset();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 5'b00000) begin bad++; $display("FAIL rst_res got vld=%b rdy=%b r=%b exp 0/1/00000", out_valid, in_ready, out_result); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 2'd0;
        in_operand = '0; in_cin = 1'b0; alu_r = '0; alu_c = 1'b0; out_ready = 1'b0;
        tick();
        test_reset();
        test_load();
        test_exec();
        test_carry_chain();
        test_hold();
        test_reset_exec();
        test_reset_result();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
